// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and FSM state encoding for the CPU memory responder.
package mem_map_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] MMIO_BASE      = 10'h3F0;
    localparam logic [ADDR_W-1:0] LOAD_LAST_ADDR = MMIO_BASE - 10'd1;
    localparam logic [2:0]        RESET_HOLD     = 3'd4;

    localparam logic [3:0] MMIO_LED  = 4'h0;
    localparam logic [3:0] MMIO_SW   = 4'h1;
    localparam logic [3:0] MMIO_CNT  = 4'h2;
    localparam logic [3:0] MMIO_STAT = 4'h3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mmio_regs.sv
// Memory-mapped I/O block: LED register, synchronized switches, free-running cycle
// counter, sticky load status, and the combinational read mux.
module mmio_regs
    import mem_map_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        switches,
    input  logic              load_complete,
    output logic [DATA_W-1:0] rdata,
    output logic [7:0]        leds
);

    logic [DATA_W-1:0] led_reg;
    logic [DATA_W-1:0] cycle_cnt;
    logic [7:0]        sw_meta;
    logic [7:0]        sw_sync;
    logic              load_seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg   <= '0;
            cycle_cnt <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            load_seen <= 1'b0;
        end else begin
            if (wr_en && offset == MMIO_LED)
                led_reg <= wdata;
            cycle_cnt <= cycle_cnt + {{(DATA_W-1){1'b0}}, 1'b1};
            sw_meta   <= switches;
            sw_sync   <= sw_meta;
            if (load_complete)
                load_seen <= 1'b1;
        end
    end

    // A write to the LED register returns the stored data; every other offset
    // returns its read value, so writes to read-only locations never echo.
    always_comb begin
        rdata = '0;
        case (offset)
            MMIO_LED:  rdata = wr_en ? wdata : led_reg;
            MMIO_SW:   rdata = {{(DATA_W-8){1'b0}}, sw_sync};
            MMIO_CNT:  rdata = cycle_cnt;
            MMIO_STAT: rdata = {{(DATA_W-1){1'b0}}, load_seen};
            default:   rdata = '0;
        endcase
    end

    assign leds = led_reg[7:0];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves CPU loads/stores from RAM and MMIO, and runs the
// host program loader that holds the CPU in reset while an image is streamed in.
module mem_responder
    import mem_map_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic [7:0]        switches,
    output logic [7:0]        leds
);

    state_t            state, state_next;
    logic [2:0]        hold_cnt, hold_next;
    logic              from_load, from_load_next;
    logic [ADDR_W-1:0] load_ptr, ptr_next;
    logic              done_next;
    logic              load_complete;

    logic              is_mmio;
    logic              mmio_wr;
    logic [DATA_W-1:0] mmio_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_HOLD;
            hold_cnt  <= RESET_HOLD;
            from_load <= 1'b0;
            load_ptr  <= '0;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            from_load <= from_load_next;
            load_ptr  <= ptr_next;
            cpu_reset <= (state_next != ST_RUN);
            load_done <= done_next;
        end
    end

    // from_load remembers whether HOLD was entered after a finished load, so the
    // post-reset hold never produces a load_done pulse.
    always_comb begin
        state_next     = state;
        hold_next      = hold_cnt;
        from_load_next = from_load;
        ptr_next       = load_ptr;
        done_next      = 1'b0;
        load_complete  = 1'b0;
        case (state)
            ST_RUN: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    ptr_next = load_ptr + 10'd1;
                    if (load_last || load_ptr == LOAD_LAST_ADDR) begin
                        state_next     = ST_HOLD;
                        hold_next      = RESET_HOLD;
                        from_load_next = 1'b1;
                        load_complete  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt <= 3'd1) begin
                    state_next     = ST_RUN;
                    done_next      = from_load;
                    from_load_next = 1'b0;
                end else begin
                    hold_next = hold_cnt - 3'd1;
                end
            end
            default: state_next = ST_HOLD;
        endcase
    end

    assign load_ready = (state == ST_LOAD);
    assign is_mmio    = (cpu_addr >= MMIO_BASE);
    assign mmio_wr    = (state == ST_RUN) && cpu_we && is_mmio;

    mmio_regs u_mmio (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (mmio_wr),
        .offset        (cpu_addr[3:0]),
        .wdata         (cpu_wdata),
        .switches      (switches),
        .load_complete (load_complete && !reset),
        .rdata         (mmio_rdata),
        .leds          (leds)
    );

    // Single RAM port shared between the loader and the CPU; only one of them
    // owns it in any given state.
    assign ram_addr  = (state == ST_LOAD) ? load_ptr : cpu_addr;
    assign ram_wdata = (state == ST_LOAD) ? load_data : cpu_wdata;
    assign ram_we    = !reset &&
                       (((state == ST_LOAD) && load_valid) ||
                        ((state == ST_RUN) && cpu_we && !is_mmio));

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cpu_rdata <= '0;
        else if (state != ST_RUN)
            cpu_rdata <= '0;
        else if (is_mmio)
            cpu_rdata <= mmio_rdata;
        else if (cpu_we)
            cpu_rdata <= cpu_wdata;
        else
            cpu_rdata <= ram[ram_addr];
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: reads push expected data, a monitor pops
// and compares one cycle later; loader and reset sequencing are checked directly.
module tb_mem_responder;
    import mem_map_pkg::*;

    logic        clk;
    logic        reset;
    logic [9:0]  cpu_addr;
    logic        cpu_we;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_reset;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [7:0]  switches;
    logic [7:0]  leds;

    int tests_run = 0;
    int tests_failed = 0;

    string       name_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] words[$];
    logic        req_issue = 1'b0;
    logic        resp_due = 1'b0;
    logic [15:0] cyc_model;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_reset  (cpu_reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .switches   (switches),
        .leds       (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: cleared by reset, +1 every edge, wraps naturally.
    always @(posedge clk) begin
        if (reset) cyc_model <= 16'h0;
        else       cyc_model <= cyc_model + 16'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; drives one CPU access and queues its expected read data.
    task automatic applyStimulus(input string name, input logic [9:0] addr, input logic we,
                                 input logic [15:0] wdata, input logic [15:0] expected);
        cpu_addr  = addr;
        cpu_we    = we;
        cpu_wdata = wdata;
        req_issue = 1'b1;
        name_q.push_back(name);
        exp_q.push_back(expected);
        @(negedge clk);
        req_issue = 1'b0;
        cpu_we    = 1'b0;
    endtask

    always @(posedge clk) resp_due <= req_issue;

    always @(negedge clk) begin
        if (resp_due) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL scoreboard: response 0x%0h with no expected entry", cpu_rdata);
            end else begin
                checkOutput(name_q.pop_front(), {16'h0, cpu_rdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic waitRun(output int hi, output int dn);
        hi = 0;
        dn = 0;
        for (int c = 0; c < 100; c++) begin
            if (!cpu_reset) begin
                if (load_done) dn++;
                return;
            end
            hi++;
            if (load_done) dn++;
            @(negedge clk);
        end
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL wait_run: cpu_reset still high after 100 cycles, expected low");
    endtask

    // Streams the words queue; valid is held whenever words remain, so words
    // offered while load_ready is low must be ignored by the DUT.
    task automatic streamLoad(input bit use_last, output int rst_cnt, output int acc_cnt,
                              output int rdy_cnt, output int done_cnt);
        int idx;
        idx = 0;
        rst_cnt = 0; acc_cnt = 0; rdy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!cpu_reset) begin
                if (load_done) done_cnt++;
                load_valid = 1'b0;
                load_last  = 1'b0;
                return;
            end
            rst_cnt++;
            if (load_done) done_cnt++;
            if (load_ready) rdy_cnt++;
            if (idx < words.size()) begin
                load_valid = 1'b1;
                load_data  = words[idx];
                load_last  = use_last && (idx == words.size() - 1);
                if (load_ready) begin
                    acc_cnt++;
                    idx++;
                end
            end else begin
                load_valid = 1'b0;
                load_last  = 1'b0;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL stream_load: cpu_reset still high after 3000 cycles, expected low");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi, dn, rst_cnt, acc_cnt, rdy_cnt, done_cnt;
        reset      = 1'b1;
        cpu_addr   = '0;
        cpu_we     = 1'b0;
        cpu_wdata  = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        switches   = 8'h00;
        repeat (3) @(negedge clk);

        checkOutput("reset_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        checkOutput("reset_load_ready", {31'b0, load_ready}, 32'd0);
        checkOutput("reset_load_done", {31'b0, load_done}, 32'd0);
        checkOutput("reset_leds", {24'b0, leds}, 32'h0);
        checkOutput("reset_rdata", {16'b0, cpu_rdata}, 32'h0);
        reset = 1'b0;
        waitRun(hi, dn);
        checkOutput("post_reset_hold_cycles", hi, 4);
        checkOutput("post_reset_load_done", dn, 0);
        applyStimulus("rd_led_after_reset", 10'h3F0, 1'b0, 16'h0, 16'h0000);

        // Load start coincides with a CPU store; the store still lands.
        load_start = 1'b1;
        applyStimulus("wr_with_load_start", 10'h100, 1'b1, 16'h0077, 16'h0077);
        load_start = 1'b0;
        words = '{16'h1111, 16'h2222, 16'h3333};
        streamLoad(1'b1, rst_cnt, acc_cnt, rdy_cnt, done_cnt);
        checkOutput("load3_ready_cycles", rdy_cnt, 3);
        checkOutput("load3_accepted", acc_cnt, 3);
        checkOutput("load3_cpu_reset_cycles", rst_cnt, 7);
        checkOutput("load3_done_pulses", done_cnt, 1);
        applyStimulus("rd_ram0", 10'h000, 1'b0, 16'h0, 16'h1111);
        applyStimulus("rd_ram1", 10'h001, 1'b0, 16'h0, 16'h2222);
        applyStimulus("rd_ram2", 10'h002, 1'b0, 16'h0, 16'h3333);
        applyStimulus("rd_ram100", 10'h100, 1'b0, 16'h0, 16'h0077);
        applyStimulus("rd_status_loaded", 10'h3F3, 1'b0, 16'h0, 16'h0001);
        checkOutput("done_low_after_pulse", {31'b0, load_done}, 32'd0);

        applyStimulus("wr_led", 10'h3F0, 1'b1, 16'h00AB, 16'h00AB);
        checkOutput("leds_after_write", {24'b0, leds}, 32'hAB);
        applyStimulus("wr_counter_ro", 10'h3F2, 1'b1, 16'hFFFF, cyc_model);
        applyStimulus("rd_counter_after_wr", 10'h3F2, 1'b0, 16'h0, cyc_model);
        applyStimulus("wr_ram10", 10'h010, 1'b1, 16'h1234, 16'h1234);
        applyStimulus("rd_ram10", 10'h010, 1'b0, 16'h0, 16'h1234);
        applyStimulus("wr_unmapped", 10'h3F5, 1'b1, 16'h5555, 16'h0000);
        applyStimulus("rd_unmapped", 10'h3F4, 1'b0, 16'h0, 16'h0000);
        applyStimulus("wr_switch_ro", 10'h3F1, 1'b1, 16'h00FF, 16'h0000);
        applyStimulus("rd_led_kept", 10'h3F0, 1'b0, 16'h0, 16'h00AB);

        switches = 8'h5A;
        repeat (3) @(negedge clk);
        applyStimulus("rd_switches", 10'h3F1, 1'b0, 16'h0, 16'h005A);
        applyStimulus("rd_counter_a", 10'h3F2, 1'b0, 16'h0, cyc_model);
        repeat (3) @(negedge clk);
        applyStimulus("rd_counter_b", 10'h3F2, 1'b0, 16'h0, cyc_model);

        // Capacity load: two extra words beyond the RAM region must be refused.
        words.delete();
        for (int i = 0; i < 16'h3F2; i++) words.push_back(16'h4000 + 16'(i));
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        streamLoad(1'b0, rst_cnt, acc_cnt, rdy_cnt, done_cnt);
        checkOutput("cap_accepted", acc_cnt, 32'h3F0);
        checkOutput("cap_ready_cycles", rdy_cnt, 32'h3F0);
        checkOutput("cap_cpu_reset_cycles", rst_cnt, 32'h3F4);
        checkOutput("cap_done_pulses", done_cnt, 1);
        checkOutput("cap_leds_kept", {24'b0, leds}, 32'hAB);
        applyStimulus("cap_rd_3ef", 10'h3EF, 1'b0, 16'h0, 16'h43EF);
        applyStimulus("cap_rd_000", 10'h000, 1'b0, 16'h0, 16'h4000);
        applyStimulus("cap_rd_led", 10'h3F0, 1'b0, 16'h0, 16'h00AB);

        // Reset in the middle of a load keeps the partial image, no load_done.
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checkOutput("abort_ready_in_load", {31'b0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = 16'hBEEF;
        @(negedge clk);
        load_data  = 16'hCAFE;
        @(negedge clk);
        load_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        waitRun(hi, dn);
        checkOutput("abort_hold_cycles", hi, 4);
        checkOutput("abort_load_done", dn, 0);
        checkOutput("abort_leds_cleared", {24'b0, leds}, 32'h0);
        applyStimulus("abort_rd_ram0", 10'h000, 1'b0, 16'h0, 16'hBEEF);
        applyStimulus("abort_rd_ram1", 10'h001, 1'b0, 16'h0, 16'hCAFE);
        applyStimulus("abort_rd_ram2", 10'h002, 1'b0, 16'h0, 16'h4002);
        applyStimulus("abort_rd_status", 10'h3F3, 1'b0, 16'h0, 16'h0000);

        @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
